hdmi_pll_seq: RTL and testbench
===============================

HDMI_PLL_SEQ -- requirements
Module: hdmi_pll_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_reset is held high per reset attempt (range 1..65535).
REQ-002 Parameter LOCK_FILTER, default 1024: consecutive synchronized-lock-high cycles required before declaring the PLL stable (range 1..65535).
REQ-003 Parameter LOCK_TIMEOUT, default 50000: cycles to wait for lock before a retry (range 1..65535).
REQ-004 Parameter MAX_RETRY, default 7: retries allowed before FAIL (range 0..15).
REQ-005 clk  in  1  free-running 50 MHz board clock; it is the same clock that feeds the HDMI PLL clkin.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 pll_lock  in  1  PLL lock flag, asynchronous to clk.
REQ-008 relock_req  in  1  single-cycle request to restart the PLL bring-up.
REQ-009 pll_reset  out  1  drives the PLL RESET pin, active-high.
REQ-010 hdmi_rst  out  1  reset for the pixel/serializer domains, active-high; it equals NOT ready.
REQ-011 ready  out  1  PLL clocks are stable.
REQ-012 fail  out  1  retry budget is exhausted.
REQ-013 retry_cnt  out  4  timeouts in the current bring-up.
REQ-014 loss_cnt  out  8  lock losses observed while in RUN; saturates at 255.

Function
REQ-015 pll_lock SHALL pass through a 2-flop synchronizer (lock_s) before use; this adds 2 cycles of latency, and the flops reset to 0.
REQ-016 The FSM SHALL have the states RESET, WAIT_LOCK, FILTER, RUN and FAIL, plus a single 16-bit counter cnt that is cleared on every state change.
REQ-017 RESET: when cnt==RST_CYCLES-1, go to WAIT_LOCK; pll_reset is therefore high for exactly RST_CYCLES cycles.
REQ-018 WAIT_LOCK transitions:
- lock_s==1: go to FILTER.
- Otherwise, when cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY, go to FAIL; else increment retry_cnt and go to RESET.
- If lock_s==1 and the timeout occur in the same cycle, the lock wins.
REQ-019 FILTER transitions:
- lock_s==0: go to WAIT_LOCK, with the timeout count restarting at 0.
- lock_s==1 and cnt==LOCK_FILTER-1: go to RUN and clear retry_cnt.
REQ-020 RUN: lock_s==0 SHALL cause a transition to RESET and increment loss_cnt (saturating).
REQ-021 FAIL: the FSM SHALL hold in FAIL with pll_reset=1 until relock_req.
REQ-022 relock_req SHALL have the following effect:
- In WAIT_LOCK, FILTER, RUN or FAIL: force RESET with cnt=0 and clear retry_cnt.
- In RESET: ignored.
- It takes priority over all other transitions in the same cycle.
REQ-023 All outputs SHALL be registered and SHALL decode the current state:
- pll_reset = RESET or FAIL.
- ready = RUN.
- hdmi_rst = NOT RUN.
- fail = FAIL.
REQ-024 Lock-loss latency: ready SHALL fall and hdmi_rst SHALL rise exactly 3 clk edges after pll_lock falls (2 synchronizer edges plus 1 state edge), with no glitch.
REQ-025 Counter compares SHALL use 16-bit unsigned equality; cnt SHALL never wrap inside a state.

Reset
REQ-026 While rst=1, the block SHALL hold these values:
- State RESET with cnt=0 and lock_s=0.
- pll_reset=1, hdmi_rst=1.
- ready=0, fail=0.
- retry_cnt=0, loss_cnt=0.
REQ-027 Assertion of rst in any state SHALL return all outputs to the REQ-026 values immediately, without waiting for a clk edge.
REQ-028 After rst deasserts, the FSM SHALL begin the RESET state on the first clk edge.

Verification (RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=20, MAX_RETRY=2; edge 1 = first clk edge after rst falls)
REQ-029 Bring-up scenario:
- Stimulus: pll_lock tied 1.
- Response: pll_reset is high for edges 1-4; the FSM is in FILTER for edges 6-13; ready=1 and hdmi_rst=0 from edge 14; retry_cnt=0.
REQ-030 No-lock scenario:
- Stimulus: pll_lock tied 0.
- Response: three pll_reset pulses of 4 cycles each, with retry_cnt stepping 0, 1, 2, and attempts spaced 24 cycles apart; fail=1 after the third timeout; pll_reset then stays 1; ready stays 0.
REQ-031 Filter glitch scenario:
- Stimulus: pll_lock drops for 1 cycle at FILTER cnt=5.
- Response: the FSM returns to WAIT_LOCK, then to FILTER, and ready rises 8 cycles after lock_s is high again; retry_cnt is unchanged.
REQ-032 Lock loss in RUN scenario:
- Stimulus: pll_lock falls while in RUN.
- Response: ready=0 and hdmi_rst=1 on the 3rd edge; loss_cnt=1; a 4-cycle pll_reset pulse follows; ready reasserts after re-lock.
- Repeating this 256 times leaves loss_cnt=255.
REQ-033 Recovery from FAIL scenario:
- Stimulus: relock_req pulsed in FAIL with pll_lock=1.
- Response: fail=0 and retry_cnt=0 on the next edge; pll_reset is high for 4 cycles; ready=1 after the filter; relock_req pulses issued during RESET are ignored.
REQ-034 Asynchronous reset scenario:
- Stimulus: rst asserted mid-FILTER (cnt=3).
- Response: REQ-026 values appear before the next clk edge; after release, the REQ-029 timing repeats exactly.

Source files
------------

// File: rtl/hdmi_pll_seq.sv
// HDMI PLL bring-up sequencer: pulses the PLL reset, waits for a filtered lock,
// retries on timeout, and holds the pixel/serializer domains in reset until stable.
module hdmi_pll_seq #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_FILTER  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       hdmi_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_FILTER,
    ST_RUN,
    ST_FAIL
  } state_e;

  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] FILTER_LAST  = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic        sync1_q, lock_s_q;
  logic        pll_reset_q, hdmi_rst_q, ready_q, fail_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (relock_req && state_q != ST_RESET) begin
      state_d = ST_RESET;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_FILTER;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        ST_FILTER: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == FILTER_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_RESET;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end

    // Counting states always leave at their terminal count, so cnt cannot wrap.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_RESET || state_q == ST_WAIT_LOCK || state_q == ST_FILTER) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      hdmi_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      // Outputs are decoded from the next state so they line up with state_q.
      pll_reset_q <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      hdmi_rst_q  <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  assign pll_reset = pll_reset_q;
  assign hdmi_rst  = hdmi_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_hdmi_pll_seq.sv
// Self-checking bench for hdmi_pll_seq: directed bring-up/fail/loss scenarios plus
// randomized lock and relock traffic against a phase/elapsed-time reference model.
module tb_hdmi_pll_seq;

  localparam int RST_C     = 4;
  localparam int FILTER_C  = 8;
  localparam int TIMEOUT_C = 20;
  localparam int RETRY_C   = 2;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_FILTER = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset, hdmi_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int errors = 0;
  int checks = 0;

  int m_phase, m_elapsed, m_retry, m_loss;
  bit m_s1, m_ls;

  hdmi_pll_seq #(
    .RST_CYCLES  (RST_C),
    .LOCK_FILTER (FILTER_C),
    .LOCK_TIMEOUT(TIMEOUT_C),
    .MAX_RETRY   (RETRY_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .relock_req(relock_req),
    .pll_reset (pll_reset),
    .hdmi_rst  (hdmi_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RESET; m_elapsed = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_ls = 0;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_elapsed = 0;
  endtask

  // One clock edge of the reference: lock is seen through a two-edge delay line.
  task automatic model_step(input bit lock, input bit relock);
    bit ls;
    ls = m_ls; m_ls = m_s1; m_s1 = lock;
    if (relock && m_phase != P_RESET) begin
      enter(P_RESET);
      m_retry = 0;
    end else begin
      case (m_phase)
        P_RESET: begin
          m_elapsed++;
          if (m_elapsed == RST_C) enter(P_WAIT);
        end
        P_WAIT: begin
          if (ls) enter(P_FILTER);
          else begin
            m_elapsed++;
            if (m_elapsed == TIMEOUT_C) begin
              if (m_retry == RETRY_C) enter(P_FAIL);
              else begin m_retry++; enter(P_RESET); end
            end
          end
        end
        P_FILTER: begin
          if (!ls) enter(P_WAIT);
          else begin
            m_elapsed++;
            if (m_elapsed == FILTER_C) begin enter(P_RUN); m_retry = 0; end
          end
        end
        P_RUN: begin
          if (!ls) begin
            enter(P_RESET);
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/pll_reset"}, 16'(pll_reset), 16'(m_phase == P_RESET || m_phase == P_FAIL));
    check({tag, "/ready"},     16'(ready),     16'(m_phase == P_RUN));
    check({tag, "/hdmi_rst"},  16'(hdmi_rst),  16'(m_phase != P_RUN));
    check({tag, "/fail"},      16'(fail),      16'(m_phase == P_FAIL));
    check({tag, "/retry_cnt"}, 16'(retry_cnt), 16'(m_retry));
    check({tag, "/loss_cnt"},  16'(loss_cnt),  16'(m_loss));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(pll_lock, relock_req);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must react without a clock.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    rst = 1'b0;
  endtask

  // Bring-up timing with lock held high, counted from the first edge after reset.
  task automatic bringup_check(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick(tag);
      if (k == 3)  check({tag, "/prst_e4"},  16'(pll_reset), 16'd1);
      if (k == 4)  check({tag, "/prst_e5"},  16'(pll_reset), 16'd0);
      if (k == 12) check({tag, "/ready_e13"}, 16'(ready), 16'd0);
      if (k == 13) begin
        check({tag, "/ready_e14"}, 16'(ready), 16'd1);
        check({tag, "/hrst_e14"},  16'(hdmi_rst), 16'd0);
      end
    end
    check({tag, "/retry"}, 16'(retry_cnt), 16'd0);
  endtask

  initial begin
    int hold;
    rst = 1'b1; pll_lock = 1'b1; relock_req = 1'b0;
    model_reset();
    #12;
    compare_all("reset");

    // Bring-up, then asynchronous reset at FILTER cnt=3 and an identical repeat.
    rst = 1'b0;
    bringup_check("bringup");
    pulse_reset("rst2");
    for (int k = 0; k < 8; k++) tick("to_filter");
    pulse_reset("async_mid_filter");
    bringup_check("bringup_again");

    // No lock: three attempts, then FAIL.
    pll_lock = 1'b0;
    pulse_reset("nolock_rst");
    for (int k = 0; k < 80; k++) tick("nolock");
    check("nolock/fail", 16'(fail), 16'd1);
    check("nolock/retry", 16'(retry_cnt), 16'd2);
    check("nolock/prst", 16'(pll_reset), 16'd1);

    // Recovery from FAIL; a second relock pulse lands in RESET and is ignored.
    pll_lock = 1'b1; relock_req = 1'b1;
    tick("relock");
    check("relock/fail", 16'(fail), 16'd0);
    check("relock/retry", 16'(retry_cnt), 16'd0);
    tick("relock_hold");
    relock_req = 1'b0;
    for (int k = 0; k < 20; k++) tick("relock_up");
    check("relock/ready", 16'(ready), 16'd1);

    // One-cycle lock glitch at FILTER cnt=5.
    pulse_reset("glitch_rst");
    for (int k = 0; k < 10; k++) tick("glitch_pre");
    pll_lock = 1'b0;
    tick("glitch");
    pll_lock = 1'b1;
    for (int k = 0; k < 20; k++) tick("glitch_post");
    check("glitch/ready", 16'(ready), 16'd1);
    check("glitch/retry", 16'(retry_cnt), 16'd0);

    // 256 lock losses in RUN: 3-edge latency each time, loss_cnt saturates.
    for (int n = 0; n < 256; n++) begin
      pll_lock = 1'b0;
      tick("loss");
      tick("loss");
      check("loss/ready_e2", 16'(ready), 16'd1);
      tick("loss");
      check("loss/ready_e3", 16'(ready), 16'd0);
      check("loss/hrst_e3", 16'(hdmi_rst), 16'd1);
      pll_lock = 1'b1;
      for (int k = 0; k < 16; k++) tick("loss_relock");
      check("loss/ready_back", 16'(ready), 16'd1);
    end
    check("loss/saturated", 16'(loss_cnt), 16'd255);

    // Randomized lock bursts, relock pulses and asynchronous resets.
    pulse_reset("rand_rst");
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 9) < 7) begin pll_lock = 1'b1; hold = $urandom_range(1, 60); end
        else begin pll_lock = 1'b0; hold = $urandom_range(1, 90); end
      end
      hold--;
      relock_req = ($urandom_range(0, 79) == 0);
      tick("rand");
      if ($urandom_range(0, 499) == 0) pulse_reset("rand_async");
    end
    relock_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
